avalon_seg_display_ctrl: RTL and testbench
==========================================

// Module: avalon_seg_display_ctrl
// PURPOSE
// Avalon-MM slave driving NUM_SEGMENT seven-segment digits (DE1-SoC HEX0..HEXn).
// Per-digit hex decode or raw segment mode, per-digit blank and blink, global enable, PWM brightness.
// All registers read back. Sits on the HPS/Nios lightweight bus; outputs go straight to the HEX pins.
// PARAMETERS
// NUM_SEGMENT  6  number of digits, 1..14
// PWM_W        4  brightness PWM counter width
// ACTIVE_LOW   1  1: segment lit = 0 (DE1-SoC), 0: lit = 1
// PORTS
// clk                 in   1              system clock
// rst                 in   1              asynchronous reset, active-high
// avms_address_i      in   4              word address
// avms_byteenable_i   in   4              byte lanes for write
// avms_write_i        in   1              write strobe
// avms_writedata_i    in   32             write data
// avms_read_i         in   1              read strobe
// avms_readdata_o     out  32             read data, valid with readdatavalid
// avms_readdatavalid_o out 1              one-cycle pulse, 1 cycle after read
// segment_symbol_o    out  NUM_SEGMENT*7  digit k at [7k+6:7k], bit0 = seg a
// BEHAVIOUR
// - Map: addr k<NUM_SEGMENT = DIGIT[k]; NUM_SEGMENT = CTRL; NUM_SEGMENT+1 = BLINK_PERIOD; others: write ignored, read 0.
// - DIGIT[k]: [3:0] hex, [7] blank, [14:8] raw pattern (1=lit), [16] raw_sel, [17] blink_en; other bits read 0. Reset 0.
// - CTRL: [PWM_W:0] brightness, [8] enable; reset brightness=2**PWM_W, enable=1.
// - BLINK_PERIOD: 32-bit half-period in clk cycles; reset 0.
// - Writes: byte-lane granular, take effect the cycle after avms_write_i sampled; no waitrequest.
// - Reads: readdata/readdatavalid registered, latency 1; readdata holds last value otherwise.
//   Read and write same address same cycle: read returns pre-write value.
// - Blink: down-counter; loaded with BLINK_PERIOD-1 on reload; at 0 reloads and toggles blink_phase.
//   BLINK_PERIOD write restarts counter and sets blink_phase=1. BLINK_PERIOD=0: phase held 1.
// - PWM: free-running PWM_W-bit counter, wraps; pwm_on = (pwm_cnt < brightness).
//   brightness>=2**PWM_W: always on; 0: always off.
// - Digit k lit pattern: raw_sel ? raw : hexdecode(hex) (standard 0-9,A,b,C,d,E,F).
//   Forced 0 if blank | !enable | !pwm_on | (blink_en & !blink_phase).
// - Output: pattern registered, XOR all-ones if ACTIVE_LOW. Write accept -> pin change 2 cycles after write strobe.
// - Reset (any time, mid-blink/mid-read): all regs to reset values, counters 0, blink_phase=1,
//   readdatavalid=0, readdata=0, segment_symbol_o = all off (all 1s if ACTIVE_LOW).
// TESTING
// - Reset -> segment_symbol_o=42'h3FF_FFFF_FFFF; read CTRL -> 32'h0000_0110 (PWM_W=4).
// - Write DIGIT[2]=0x5, be=4'h1 -> 2 cycles later bits[20:14]=~7'h6D; read DIGIT[2] -> 0x5 next cycle.
// - Write DIGIT[0]=0x0001_7F00 (raw_sel, raw 7F), be=4'hF -> digit0 = 7'h00; be=4'h2 only -> raw_sel stays 0.
// - BLINK_PERIOD=4, DIGIT[1] blink_en -> digit1 toggles lit/off every 4 clk; digit0 steady.
// - CTRL brightness=4, PWM_W=4 -> lit digits on 4 of every 16 clk; brightness=0 -> always off.
// - Write addr NUM_SEGMENT+2 then read -> 0; assert rst mid-blink -> outputs all off same cycle.

Source files
------------

// File: rtl/avalon_seg_display_if.sv
// Avalon-MM slave bus bundle for the seven-segment display controller.
// Signal names keep the bus-side _i/_o suffixes as seen from the slave.
interface avalon_seg_display_if;
  logic [3:0]  avms_address_i;
  logic [3:0]  avms_byteenable_i;
  logic        avms_write_i;
  logic [31:0] avms_writedata_i;
  logic        avms_read_i;
  logic [31:0] avms_readdata_o;
  logic        avms_readdatavalid_o;

  modport slave (
    input  avms_address_i,
    input  avms_byteenable_i,
    input  avms_write_i,
    input  avms_writedata_i,
    input  avms_read_i,
    output avms_readdata_o,
    output avms_readdatavalid_o
  );

  modport master (
    output avms_address_i,
    output avms_byteenable_i,
    output avms_write_i,
    output avms_writedata_i,
    output avms_read_i,
    input  avms_readdata_o,
    input  avms_readdatavalid_o
  );
endinterface

// File: rtl/avalon_seg_display_ctrl.sv
// Avalon-MM controlled seven-segment driver: per-digit hex/raw, blank, blink,
// global enable and PWM brightness, with a registered output stage.
module avalon_seg_display_ctrl #(
  parameter int NUM_SEGMENT = 6,
  parameter int PWM_W       = 4,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  avalon_seg_display_if.slave      avms,
  output logic [NUM_SEGMENT*7-1:0] segment_symbol_o
);

  localparam logic [31:0] DIGIT_MASK = 32'h0003_7F8F;
  localparam logic [31:0] CTRL_MASK  = ((32'd1 << (PWM_W + 1)) - 32'd1) | 32'h0000_0100;
  localparam logic [31:0] CTRL_RESET = (32'd1 << PWM_W) | 32'h0000_0100;
  localparam logic [3:0]  ADDR_CTRL  = 4'(NUM_SEGMENT);
  localparam logic [3:0]  ADDR_BLINK = 4'(NUM_SEGMENT + 1);
  localparam logic [NUM_SEGMENT*7-1:0] SEG_POL = {(NUM_SEGMENT*7){ACTIVE_LOW != 0}};

  logic [31:0]              r_digit [NUM_SEGMENT];
  logic [31:0]              r_ctrl;
  logic [31:0]              r_blink_period;
  logic [31:0]              r_blink_cnt;
  logic                     r_blink_phase;
  logic [PWM_W-1:0]         r_pwm_cnt;
  logic [31:0]              r_readdata;
  logic                     r_readdatavalid;
  logic [NUM_SEGMENT*7-1:0] r_seg;

  logic [31:0]              w_rd_mux;
  logic [31:0]              w_be_mask;
  logic [31:0]              w_merged;
  logic                     w_wr_blink;
  logic                     w_pwm_on;
  logic [NUM_SEGMENT*7-1:0] w_pattern;

  function automatic logic [6:0] f_hex7(input logic [3:0] v);
    case (v)
      4'h0: f_hex7 = 7'h3F;
      4'h1: f_hex7 = 7'h06;
      4'h2: f_hex7 = 7'h5B;
      4'h3: f_hex7 = 7'h4F;
      4'h4: f_hex7 = 7'h66;
      4'h5: f_hex7 = 7'h6D;
      4'h6: f_hex7 = 7'h7D;
      4'h7: f_hex7 = 7'h07;
      4'h8: f_hex7 = 7'h7F;
      4'h9: f_hex7 = 7'h6F;
      4'hA: f_hex7 = 7'h77;
      4'hB: f_hex7 = 7'h7C;
      4'hC: f_hex7 = 7'h39;
      4'hD: f_hex7 = 7'h5E;
      4'hE: f_hex7 = 7'h79;
      default: f_hex7 = 7'h71;
    endcase
  endfunction

  // The read mux doubles as the "old value" for byte-lane merging on writes.
  always_comb begin
    w_rd_mux = '0;
    for (int k = 0; k < NUM_SEGMENT; k++) begin
      if (avms.avms_address_i == 4'(k)) w_rd_mux = r_digit[k];
    end
    if (avms.avms_address_i == ADDR_CTRL)  w_rd_mux = r_ctrl;
    if (avms.avms_address_i == ADDR_BLINK) w_rd_mux = r_blink_period;
  end

  assign w_be_mask  = {{8{avms.avms_byteenable_i[3]}}, {8{avms.avms_byteenable_i[2]}},
                       {8{avms.avms_byteenable_i[1]}}, {8{avms.avms_byteenable_i[0]}}};
  assign w_merged   = (w_rd_mux & ~w_be_mask) | (avms.avms_writedata_i & w_be_mask);
  assign w_wr_blink = avms.avms_write_i && (avms.avms_address_i == ADDR_BLINK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_SEGMENT; k++) r_digit[k] <= '0;
      r_ctrl         <= CTRL_RESET;
      r_blink_period <= '0;
    end else if (avms.avms_write_i) begin
      for (int k = 0; k < NUM_SEGMENT; k++) begin
        if (avms.avms_address_i == 4'(k)) r_digit[k] <= w_merged & DIGIT_MASK;
      end
      if (avms.avms_address_i == ADDR_CTRL)  r_ctrl         <= w_merged & CTRL_MASK;
      if (avms.avms_address_i == ADDR_BLINK) r_blink_period <= w_merged;
    end
  end

  // Read data is captured before any same-cycle write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdatavalid <= avms.avms_read_i;
      if (avms.avms_read_i) r_readdata <= w_rd_mux;
    end
  end

  assign avms.avms_readdata_o      = r_readdata;
  assign avms.avms_readdatavalid_o = r_readdatavalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_wr_blink) begin
      r_blink_phase <= 1'b1;
      r_blink_cnt   <= (w_merged == '0) ? '0 : w_merged - 32'd1;
    end else if (r_blink_period == '0) begin
      r_blink_phase <= 1'b1;
      r_blink_cnt   <= '0;
    end else if (r_blink_cnt == '0) begin
      r_blink_cnt   <= r_blink_period - 32'd1;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt - 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pwm_cnt <= '0;
    else     r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

  // Brightness is one bit wider than the counter so full scale means always on.
  assign w_pwm_on = ({1'b0, r_pwm_cnt} < r_ctrl[PWM_W:0]);

  always_comb begin
    w_pattern = '0;
    for (int k = 0; k < NUM_SEGMENT; k++) begin
      if (!r_digit[k][7] && r_ctrl[8] && w_pwm_on && !(r_digit[k][17] && !r_blink_phase)) begin
        w_pattern[k*7 +: 7] = r_digit[k][16] ? r_digit[k][14:8] : f_hex7(r_digit[k][3:0]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_seg <= SEG_POL;
    else     r_seg <= w_pattern ^ SEG_POL;
  end

  assign segment_symbol_o = r_seg;

endmodule

// File: tb/tb_avalon_seg_display_ctrl.sv
// Self-checking bench for avalon_seg_display_ctrl: random register traffic
// compared against a cycle-indexed behavioural model of the display.
module tb_avalon_seg_display_ctrl;
  localparam int NS = 6;
  localparam int PW = 4;
  localparam logic [NS*7-1:0] ALL_OFF = 42'h3FF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NS*7-1:0] segOut;
  int checks = 0;
  int errors = 0;
  int edgeN  = 0;

  logic [31:0] mDigit [NS];
  logic [31:0] mCtrl;
  logic [31:0] mPeriod;
  int          mBlinkEdge;
  logic [6:0]  hexTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  avalon_seg_display_if av();

  avalon_seg_display_ctrl #(.NUM_SEGMENT(NS), .PWM_W(PW), .ACTIVE_LOW(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .avms             (av.slave),
    .segment_symbol_o (segOut)
  );

  always #5 clk = ~clk;

  // Edge index since reset release; edge 1 is the first clock after release.
  always @(posedge clk or posedge rst) begin
    if (rst) edgeN <= 0;
    else     edgeN <= edgeN + 1;
  end

  function automatic logic [31:0] mRead(input int a);
    if (a < NS)      return mDigit[a];
    if (a == NS)     return mCtrl;
    if (a == NS + 1) return mPeriod;
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) mDigit[k] = 32'h0;
    mCtrl      = 32'h0000_0110;
    mPeriod    = 32'h0;
    mBlinkEdge = 0;
  endtask

  task automatic model_write(input int a, input logic [3:0] be, input logic [31:0] d, input int w);
    logic [31:0] bm;
    logic [31:0] merged;
    bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    merged = (mRead(a) & ~bm) | (d & bm);
    if (a < NS)            mDigit[a] = merged & 32'h0003_7F8F;
    else if (a == NS)      mCtrl = merged & 32'h0000_011F;
    else if (a == NS + 1) begin
      mPeriod    = merged;
      mBlinkEdge = w;
    end
  endtask

  // Expected pins right after edge n: PWM position and blink phase follow from elapsed edges.
  function automatic logic [NS*7-1:0] exp_seg(input int n);
    logic [NS*7-1:0] r;
    logic [6:0] pat;
    bit pwmOn;
    bit phase;
    longint elapsed;
    pwmOn = ((n - 1) % 16) < int'(mCtrl[4:0]);
    elapsed = longint'(n - 1 - mBlinkEdge);
    phase = (mPeriod == 0) ? 1'b1 : (((elapsed / longint'(mPeriod)) % 2) == 0);
    for (int k = 0; k < NS; k++) begin
      pat = mDigit[k][16] ? mDigit[k][14:8] : hexTab[mDigit[k][3:0]];
      if (!mDigit[k][7] && mCtrl[8] && pwmOn && !(mDigit[k][17] && !phase))
        r[k*7 +: 7] = ~pat;
      else
        r[k*7 +: 7] = 7'h7F;
    end
    return r;
  endfunction

  task automatic bus_idle();
    av.avms_address_i    = 4'h0;
    av.avms_byteenable_i = 4'h0;
    av.avms_write_i      = 1'b0;
    av.avms_writedata_i  = 32'h0;
    av.avms_read_i       = 1'b0;
  endtask

  task automatic bus_write(input int a, input logic [3:0] be, input logic [31:0] d);
    av.avms_address_i    = 4'(a);
    av.avms_byteenable_i = be;
    av.avms_writedata_i  = d;
    av.avms_write_i      = 1'b1;
    @(posedge clk); #1;
    av.avms_write_i      = 1'b0;
    model_write(a, be, d, edgeN);
  endtask

  task automatic bus_read(input int a, output logic [31:0] data, output logic valid);
    av.avms_address_i = 4'(a);
    av.avms_read_i    = 1'b1;
    @(posedge clk); #1;
    av.avms_read_i    = 1'b0;
    data  = av.avms_readdata_o;
    valid = av.avms_readdatavalid_o;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    bus_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (segOut !== ALL_OFF) begin errors++; $display("[TB] FAIL reset_seg: got %h expected %h", segOut, ALL_OFF); end
    checks++;
    if (av.avms_readdatavalid_o !== 1'b0 || av.avms_readdata_o !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_read: got valid %b data %h expected 0/0", av.avms_readdatavalid_o, av.avms_readdata_o);
    end
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (segOut !== exp_seg(edgeN)) begin errors++; $display("[TB] FAIL reset_first_frame: got %h expected %h", segOut, exp_seg(edgeN)); end
    bus_read(NS, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0000_0110) begin errors++; $display("[TB] FAIL reset_ctrl: got valid %b data %h expected 1/00000110", v, d); end
    @(posedge clk); #1;
    checks++;
    if (av.avms_readdatavalid_o !== 1'b0 || av.avms_readdata_o !== 32'h0000_0110) begin
      errors++; $display("[TB] FAIL read_hold: got valid %b data %h expected 0/00000110", av.avms_readdatavalid_o, av.avms_readdata_o);
    end
  endtask

  task automatic test_hex_digit();
    logic [31:0] d;
    logic v;
    int k;
    bus_write(2, 4'h1, 32'h5);
    @(posedge clk); #1;
    checks++;
    if (segOut[20:14] !== ~7'h6D) begin errors++; $display("[TB] FAIL hex_digit2: got %h expected %h", segOut[20:14], ~7'h6D); end
    bus_read(2, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h5) begin errors++; $display("[TB] FAIL hex_read2: got valid %b data %h expected 1/5", v, d); end
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, NS - 1);
      bus_write(k, 4'($urandom_range(0, 15)), $urandom);
      @(posedge clk); #1;
      checks++;
      if (segOut !== exp_seg(edgeN)) begin errors++; $display("[TB] FAIL rand_seg[%0d]: got %h expected %h", i, segOut, exp_seg(edgeN)); end
      bus_read(k, d, v);
      checks++;
      if (v !== 1'b1 || d !== mRead(k)) begin errors++; $display("[TB] FAIL rand_read[%0d]: got %h expected %h", i, d, mRead(k)); end
    end
  endtask

  task automatic test_raw();
    logic [31:0] d;
    logic v;
    bus_write(0, 4'hF, 32'h0001_7F00);
    @(posedge clk); #1;
    checks++;
    if (segOut[6:0] !== 7'h00) begin errors++; $display("[TB] FAIL raw_all_lit: got %h expected 00", segOut[6:0]); end
    bus_write(0, 4'hF, 32'h0);
    bus_write(0, 4'h2, 32'h0001_7F00);
    @(posedge clk); #1;
    checks++;
    if (segOut[6:0] !== 7'h40) begin errors++; $display("[TB] FAIL raw_lane_seg: got %h expected 40", segOut[6:0]); end
    bus_read(0, d, v);
    checks++;
    if (d !== 32'h0000_7F00) begin errors++; $display("[TB] FAIL raw_lane_read: got %h expected 00007f00", d); end
    bus_write(0, 4'h1, 32'h0000_0085);
    @(posedge clk); #1;
    checks++;
    if (segOut[6:0] !== 7'h7F) begin errors++; $display("[TB] FAIL blank: got %h expected 7f", segOut[6:0]); end
  endtask

  task automatic test_blink();
    int litCount;
    for (int k = 0; k < NS; k++) bus_write(k, 4'hF, 32'h0);
    bus_write(0, 4'hF, 32'h8);
    bus_write(1, 4'hF, 32'h0002_0003);
    bus_write(NS + 1, 4'hF, 32'd4);
    litCount = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      checks++;
      if (segOut !== exp_seg(edgeN)) begin errors++; $display("[TB] FAIL blink_cycle[%0d]: got %h expected %h", i, segOut, exp_seg(edgeN)); end
      if (segOut[13:7] !== 7'h7F) litCount++;
    end
    checks++;
    if (litCount !== 12) begin errors++; $display("[TB] FAIL blink_duty: got %0d expected 12", litCount); end
  endtask

  task automatic test_pwm();
    int litCount;
    logic [31:0] bright;
    bus_write(NS + 1, 4'hF, 32'd0);
    bus_write(NS, 4'hF, 32'h0000_0104);
    litCount = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      checks++;
      if (segOut !== exp_seg(edgeN)) begin errors++; $display("[TB] FAIL pwm4_cycle[%0d]: got %h expected %h", i, segOut, exp_seg(edgeN)); end
      if (segOut[6:0] !== 7'h7F) litCount++;
    end
    checks++;
    if (litCount !== 4) begin errors++; $display("[TB] FAIL pwm4_duty: got %0d expected 4", litCount); end
    bus_write(NS, 4'hF, 32'h0000_0100);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      checks++;
      if (segOut !== ALL_OFF) begin errors++; $display("[TB] FAIL pwm0_off[%0d]: got %h expected %h", i, segOut, ALL_OFF); end
    end
    bus_write(NS, 4'hF, 32'h0000_0010);
    @(posedge clk); #1;
    checks++;
    if (segOut !== ALL_OFF) begin errors++; $display("[TB] FAIL disable_off: got %h expected %h", segOut, ALL_OFF); end
    for (int r = 0; r < 4; r++) begin
      bright = 32'($urandom_range(0, 31));
      bus_write(NS, 4'hF, 32'h0000_0100 | bright);
      for (int i = 0; i < 16; i++) begin
        @(posedge clk); #1;
        checks++;
        if (segOut !== exp_seg(edgeN)) begin errors++; $display("[TB] FAIL pwm_rand[%0d/%0d]: got %h expected %h", r, i, segOut, exp_seg(edgeN)); end
      end
    end
    bus_write(NS, 4'hF, 32'h0000_0110);
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic v;
    bus_write(NS + 2, 4'hF, $urandom | 32'h1);
    bus_read(NS + 2, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_read: got valid %b data %h expected 1/0", v, d); end
    bus_read(15, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL addr15_read: got %h expected 0", d); end
    bus_read(NS, d, v);
    checks++;
    if (d !== mRead(NS)) begin errors++; $display("[TB] FAIL unmapped_side_effect: got %h expected %h", d, mRead(NS)); end
  endtask

  task automatic test_rw_same();
    logic [31:0] d;
    logic v;
    bus_write(3, 4'hF, 32'hA);
    av.avms_address_i    = 4'd3;
    av.avms_byteenable_i = 4'hF;
    av.avms_writedata_i  = 32'hB;
    av.avms_write_i      = 1'b1;
    av.avms_read_i       = 1'b1;
    @(posedge clk); #1;
    av.avms_write_i = 1'b0;
    av.avms_read_i  = 1'b0;
    d = av.avms_readdata_o;
    model_write(3, 4'hF, 32'hB, edgeN);
    checks++;
    if (d !== 32'hA) begin errors++; $display("[TB] FAIL rw_same_old: got %h expected 0000000a", d); end
    bus_read(3, d, v);
    checks++;
    if (d !== 32'hB) begin errors++; $display("[TB] FAIL rw_same_new: got %h expected 0000000b", d); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NS; k++) bus_write(k, 4'hF, {$urandom} & 32'h0001_FF8F);
    @(posedge clk); #1;
    checks++;
    if (segOut !== exp_seg(edgeN)) begin errors++; $display("[TB] FAIL b2b_write_seg: got %h expected %h", segOut, exp_seg(edgeN)); end
    av.avms_read_i = 1'b1;
    for (int a = 0; a < NS + 3; a++) begin
      av.avms_address_i = 4'(a);
      @(posedge clk); #1;
      checks++;
      if (av.avms_readdatavalid_o !== 1'b1 || av.avms_readdata_o !== mRead(a)) begin
        errors++; $display("[TB] FAIL b2b_read[%0d]: got valid %b data %h expected 1/%h", a, av.avms_readdatavalid_o, av.avms_readdata_o, mRead(a));
      end
    end
    av.avms_read_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (av.avms_readdatavalid_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_valid_drop: got %b expected 0", av.avms_readdatavalid_o); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic v;
    bus_write(1, 4'hF, 32'h0002_0007);
    bus_write(NS + 1, 4'hF, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    bus_read(1, d, v);
    av.avms_address_i = 4'(NS);
    av.avms_read_i    = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (segOut !== ALL_OFF) begin errors++; $display("[TB] FAIL midreset_seg: got %h expected %h", segOut, ALL_OFF); end
    checks++;
    if (av.avms_readdatavalid_o !== 1'b0 || av.avms_readdata_o !== 32'h0) begin
      errors++; $display("[TB] FAIL midreset_read: got valid %b data %h expected 0/0", av.avms_readdatavalid_o, av.avms_readdata_o);
    end
    av.avms_read_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (segOut !== ALL_OFF) begin errors++; $display("[TB] FAIL midreset_hold: got %h expected %h", segOut, ALL_OFF); end
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (segOut !== exp_seg(edgeN)) begin errors++; $display("[TB] FAIL midreset_frame: got %h expected %h", segOut, exp_seg(edgeN)); end
    bus_read(NS, d, v);
    checks++;
    if (d !== 32'h0000_0110) begin errors++; $display("[TB] FAIL midreset_ctrl: got %h expected 00000110", d); end
    bus_read(1, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL midreset_digit: got %h expected 0", d); end
    bus_read(NS + 1, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL midreset_period: got %h expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_hex_digit();
    test_raw();
    test_blink();
    test_pwm();
    test_unmapped();
    test_rw_same();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
